// File: rtl/print_scheduler_if.sv
// Request/print bundle for print_scheduler. req0/req1 are single-cycle pulses,
// and the scheduler captures the matching val on the cycle its req is high.
interface print_scheduler_if;
    logic        req0;
    logic [15:0] val0;
    logic        req1;
    logic [15:0] val1;
    logic        print_en;
    logic [15:0] value;
    logic        busy;
    logic [1:0]  pending;
    logic [1:0]  overflow;
    logic [1:0]  fsm_state;

    // Handshake: a request has no ready. It is accepted when its slot is empty
    // or is being granted that same cycle, and otherwise it is dropped and flagged in overflow.
    // print_en is a one-cycle strobe, and value holds steady until the next grant.
    modport master (
        output req0, val0, req1, val1,
        input  print_en, value, busy, pending, overflow, fsm_state
    );
    modport slave (
        input  req0, val0, req1, val1,
        output print_en, value, busy, pending, overflow, fsm_state
    );
endinterface

// File: rtl/print_scheduler.sv
// Two-slot print scheduler that shares one UART printer with a fixed post-print holdoff.
// Define PRINT_SCHED_ROUND_ROBIN_EN for round-robin arbitration; otherwise slot 0 has fixed priority.
module print_scheduler #(
    parameter int CLKS_PER_BIT    = 1085,
    parameter int CHARS_PER_PRINT = 8,
    parameter int HOLD_CYCLES     = CLKS_PER_BIT * 10 * CHARS_PER_PRINT
) (
    input logic               clk,
    input logic               rst_n,
    print_scheduler_if.slave  bus
);
    localparam int CW = $clog2(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [15:0]   slot0, slot1;
    logic [15:0]   value_q, value_nxt;
    logic [1:0]    pending_q, overflow_q;
    logic [1:0]    req, accept, grant_now;
    logic          grant_en;
    logic          gnt;

`ifdef PRINT_SCHED_ROUND_ROBIN_EN
    logic last;

    always_comb begin
        gnt = pending_q[1];
        if (pending_q == 2'b11) gnt = ~last;
    end
`else
    // Slot 1 is granted only when slot 0 is empty.
    always_comb begin
        gnt = ~pending_q[0];
    end
`endif

    assign req = {bus.req1, bus.req0};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        value_nxt = value_q;
        grant_en  = 1'b0;
        case (state)
            IDLE: begin
                if (pending_q != 2'b00) begin
                    grant_en  = 1'b1;
                    value_nxt = gnt ? slot1 : slot0;
                    cnt_nxt   = CW'(HOLD_CYCLES - 1);
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // Counting down through ISSUE makes WAIT last HOLD_CYCLES-1 cycles.
                cnt_nxt   = cnt - CW'(1);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - CW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_now = grant_en ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = req & (~pending_q | grant_now);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            value_q    <= 16'd0;
            slot0      <= 16'd0;
            slot1      <= 16'd0;
            pending_q  <= 2'b00;
            overflow_q <= 2'b00;
`ifdef PRINT_SCHED_ROUND_ROBIN_EN
            last       <= 1'b1;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            value_q    <= value_nxt;
            pending_q  <= accept | (pending_q & ~grant_now);
            overflow_q <= overflow_q | (req & ~accept);
            if (accept[0]) slot0 <= bus.val0;
            if (accept[1]) slot1 <= bus.val1;
`ifdef PRINT_SCHED_ROUND_ROBIN_EN
            if (grant_en) last <= gnt;
`endif
        end
    end

    assign bus.print_en  = (state == ISSUE);
    assign bus.busy      = (state != IDLE);
    assign bus.value     = value_q;
    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_print_scheduler.sv
// Directed bench for print_scheduler. It uses a shortened holdoff, and a negedge monitor
// checks each print_en value and cycle against a queue of expected prints.
module tb_print_scheduler;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;
    logic [47:0] exp_q[$];

    print_scheduler_if bus();

    print_scheduler #(.HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each print_en pops one expected {cycle, value}, and each busy run must last HOLD cycles.
    always @(negedge clk) begin
        logic [47:0] e;
        if (bus.print_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_print: value %0d at cycle %0d, none expected", bus.value, cyc);
            end else begin
                e = exp_q.pop_front();
                check("print_value", {16'd0, bus.value}, {16'd0, e[15:0]});
                check("print_cycle", cyc, e[47:16]);
            end
        end
        if (!rst_n) busy_run = 0;
        else if (bus.busy === 1'b1) busy_run++;
        else begin
            if (busy_run > 0) check("busy_len", busy_run, HOLD);
            busy_run = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    // Called at #1 after edge E; the request is sampled at edge E+1.
    task automatic pulse(input logic r0, input logic [15:0] v0, input logic r1, input logic [15:0] v1);
        bus.req0 = r0;
        bus.val0 = v0;
        bus.req1 = r1;
        bus.val1 = v1;
        step();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic expect_print(input logic [15:0] v, input int t);
        exp_q.push_back({t[31:0], v});
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < 10 * HOLD) begin
            step();
            n++;
        end
        check("drain_timeout", (n < 10 * HOLD) ? 32'd1 : 32'd0, 32'd1);
        check("queue_empty", exp_q.size(), 0);
        step();
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_print_en"}, {31'd0, bus.print_en}, 0);
        check({tag, "_value"},    {16'd0, bus.value}, 0);
        check({tag, "_busy"},     {31'd0, bus.busy}, 0);
        check({tag, "_pending"},  {30'd0, bus.pending}, 0);
        check({tag, "_overflow"}, {30'd0, bus.overflow}, 0);
    endtask

    initial begin
        int e;
        int g;
        int gk;
        int order[5];
        logic [15:0] slotv[2];
        logic [15:0] nv;

`ifdef PRINT_SCHED_ROUND_ROBIN_EN
        order = '{0, 1, 0, 1, 0};
`else
        order = '{0, 0, 0, 0, 1};
`endif
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.val0 = 16'd0;
        bus.val1 = 16'd0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Single request into an idle block
        e = cyc;
        expect_print(16'd10, e + 2);
        pulse(1'b1, 16'd10, 1'b0, 16'd0);
        check("single_pending", {30'd0, bus.pending}, 32'd1);
        check("single_busy_pre", {31'd0, bus.busy}, 0);
        step();
        check("single_pending_post", {30'd0, bus.pending}, 0);
        check("single_busy", {31'd0, bus.busy}, 1);
        drain();

        // Back-to-back requests from different requesters
        e = cyc;
        expect_print(16'd10, e + 2);
        expect_print(16'd30, e + 2 + HOLD + 1);
        pulse(1'b1, 16'd10, 1'b0, 16'd0);
        pulse(1'b0, 16'd0, 1'b1, 16'd30);
        drain();

        // Simultaneous requests, with the granted slot refilled on its grant edge
        e = cyc;
        slotv[0] = 16'd100;
        slotv[1] = 16'd200;
        pulse(1'b1, 16'd100, 1'b1, 16'd200);
        for (int k = 0; k < 5; k++) begin
            gk = e + 2 + k * (HOLD + 1);
            g  = order[k];
            expect_print(slotv[g], gk);
            if (k < 3) begin
                nv = 16'(101 + k);
                wait_cyc(gk - 1);
                if (g == 0) pulse(1'b1, nv, 1'b0, 16'd0);
                else        pulse(1'b0, 16'd0, 1'b1, nv);
                slotv[g] = nv;
            end
        end
        drain();
        check("rr_overflow", {30'd0, bus.overflow}, 0);

        // Refill of slot 0 on the same edge it is granted
        e = cyc;
        expect_print(16'd60, e + 2);
        pulse(1'b0, 16'd0, 1'b1, 16'd60);
        pulse(1'b1, 16'd3, 1'b0, 16'd0);
        gk = e + 2 + HOLD + 1;
        expect_print(16'd3, gk);
        expect_print(16'd7, gk + HOLD + 1);
        wait_cyc(gk - 1);
        pulse(1'b1, 16'd7, 1'b0, 16'd0);
        check("refill_pending", {30'd0, bus.pending}, 32'd1);
        drain();
        check("refill_overflow", {30'd0, bus.overflow}, 0);

        // Dropped request on a full slot sets the sticky overflow bit
        e = cyc;
        expect_print(16'd1, e + 2);
        expect_print(16'd50, e + 2 + HOLD + 1);
        pulse(1'b1, 16'd1, 1'b0, 16'd0);
        pulse(1'b0, 16'd0, 1'b1, 16'd50);
        pulse(1'b0, 16'd0, 1'b1, 16'd5);
        check("ovf_set", {30'd0, bus.overflow}, 32'd2);
        check("ovf_pending", {30'd0, bus.pending}, 32'd2);
        drain();
        check("ovf_sticky", {30'd0, bus.overflow}, 32'd2);

        // Reset mid-WAIT with slot 1 pending
        e = cyc;
        expect_print(16'd9, e + 2);
        pulse(1'b1, 16'd9, 1'b0, 16'd0);
        pulse(1'b0, 16'd0, 1'b1, 16'd11);
        wait_cyc(e + 2 + HOLD / 2);
        rst_n = 1'b0;
        step();
        check_reset_outputs("midwait");
        rst_n = 1'b1;
        repeat (3 * HOLD) step();
        check("post_reset_idle", {31'd0, bus.busy}, 0);
        e = cyc;
        expect_print(16'd12, e + 2);
        pulse(1'b1, 16'd12, 1'b0, 16'd0);
        drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/print_scheduler.md
# print_scheduler

Shares the single UART `printer` instance between two result producers (calculator result path and status/error path), so that no print request is issued while a previous decimal print is still shifting out on `tx_out`. Each requester gets a one-deep capture slot. A round-robin (or fixed-priority) arbiter grants one slot at a time. The block drives the printer's `print_en` pulse and `value` bus, then holds off for a fixed frame-time budget, because the printer exposes no busy/done signal.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1085: clocks per UART bit (125 MHz / 115200).
- `CHARS_PER_PRINT`, default 8: worst-case characters emitted per print (5 digits, sign, CR, LF).
- `HOLD_CYCLES`, default `CLKS_PER_BIT*10*CHARS_PER_PRINT` (86800): cycles the block waits after a `print_en` pulse before the next grant. Minimum 2.

Ports:
- `clk`, in, 1: sole clock; all logic rising-edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `req0`, in, 1: requester 0 print request; single-cycle pulse.
- `val0`, in, 16: requester 0 value; sampled when `req0`=1.
- `req1`, in, 1: requester 1 print request; single-cycle pulse.
- `val1`, in, 16: requester 1 value; sampled when `req1`=1.
- `print_en`, out, 1: one-cycle start pulse to printer.
- `value`, out, 16: value to printer; stable from `print_en` until the next grant.
- `busy`, out, 1: high in ISSUE and WAIT.
- `pending`, out, 2: slot-full flags, bit i = slot i.
- `overflow`, out, 2: sticky bit i set when a `req` i is dropped; cleared only by reset.

## Operation
- Slots: on `req`i=1, if slot i is empty, or is being granted in this same cycle, the block writes `val`i into slot i and sets `pending[i]`. Otherwise the request is dropped, the slot keeps its old value, and `overflow[i]` is set.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if `pending`≠0, select grant g, load `value`←slot g, clear `pending[g]` (unless re-filled the same cycle), load counter←`HOLD_CYCLES-1`, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: exactly one cycle; `print_en`=1; go to WAIT.
  - WAIT: counter decrements each cycle; at 0, go to IDLE.
- Arbitration: `last` register holds the last granted index; reset value 1, so slot 0 wins first. With both slots pending, grant `~last`; with one pending, grant it. Update `last`←g on grant.
- Counter is 17 bits unsigned for the defaults; width is `$clog2(HOLD_CYCLES)`. No wrap: it is reloaded on every grant.

## Timing
- Reset values: `print_en`=0, `value`=16'd0, `busy`=0, `pending`=2'b00, `overflow`=2'b00, state IDLE, `last`=1, counter 0.
- Latency, idle block: `req` sampled at edge N → `pending` high after N → grant at edge N+1 → `print_en` high in the cycle after edge N+1, i.e. 2 cycles after the request edge.
- Grant-to-grant spacing is exactly `HOLD_CYCLES`+1 cycles: ISSUE (1) + WAIT (`HOLD_CYCLES`-1) + IDLE arbitration (1).
- Requests during ISSUE/WAIT are captured normally and served after WAIT.
- Simultaneous `req0`/`req1` into empty slots: both captured; grants follow round-robin order.
- Reset mid-WAIT: all state returns to reset values on that edge; captured slots are lost. The printer's in-flight frame is not aborted. The integrator keeps `rst_n` low ≥`HOLD_CYCLES` if line integrity matters.

## Configuration
- `PRINT_SCHED_ROUND_ROBIN_EN` defined: round-robin arbitration using `last`, as above.
- Not defined: fixed priority, slot 0 always wins when both are pending. The `last` register is removed and slot 1 can starve.

## Test plan
- Single request: `req0` with `val0`=16'd10 → `print_en` pulse 2 cycles later, `value`=10, `busy` high for `HOLD_CYCLES`+0 cycles after ISSUE start; `pending`=00 after grant.
- Back-to-back different requesters: `req0`=10, then `req1`=30 one cycle later → grants 10 then 30, with `print_en` pulses exactly `HOLD_CYCLES`+1 cycles apart.
- Simultaneous requests, RR build, both slots refilled on every grant → grant order 0,1,0,1. With macro undefined → 0,0,0.
- Overflow: `req1`=5 while `pending[1]`=1 and slot 1 not being granted → value 5 dropped, `overflow`=2'b10 and stays set; the original slot value still prints.
- Refill on grant cycle: `req0`=7 in the same cycle slot 0 (holding 3) is granted → 3 printed, `pending[0]` stays 1, 7 printed next, `overflow`=00.
- Reset mid-WAIT: assert `rst_n`=0 for one cycle at counter ≈ 40000 with slot 1 pending → next cycle all outputs at reset values, no `print_en` until a new request arrives.
